// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit packer: frame headers, frame width,
// output-register state encoding and the frame formatting helpers.
package uart_pkg;

    localparam int FRAME_W = 56;

    localparam logic [7:0] HDR_ADS     = 8'hAA;
    localparam logic [7:0] HDR_MPR     = 8'hBB;
    localparam logic [7:0] HDR_REG_ADS = 8'h61;
    localparam logic [7:0] HDR_REG_MPR = 8'h6D;
    localparam logic [7:0] HDR_CMD_R   = 8'h52;
    localparam logic [7:0] HDR_CMD_S   = 8'h53;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic logic [FRAME_W-1:0] fmt_ads(input logic [47:0] ads);
        return {HDR_ADS, ads};
    endfunction

    function automatic logic [FRAME_W-1:0] fmt_mpr(input logic [23:0] mpr);
        return {24'h0, HDR_MPR, mpr};
    endfunction

    // Register response is {addr, data}; src selects which sensor answered.
    function automatic logic [FRAME_W-1:0] fmt_reg(input logic [15:0] resp,
                                                   input logic        src);
        return {24'h0, (src ? HDR_REG_MPR : HDR_REG_ADS), resp, 8'h00};
    endfunction

endpackage

// File: rtl/uart_pkt_slot.sv
// One-entry frame buffer with full flag, write/drain handshake and an optional
// saturating drop counter (built only when UART_PKT_DROP_CNT_EN is defined).
module uart_pkt_slot
    import uart_pkg::*;
#(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_wr,
    input  logic [FRAME_W-1:0]    i_wr_frame,
    input  logic                  i_drain,
    output logic                  o_full,
    output logic [FRAME_W-1:0]    o_frame,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    logic               full_q, full_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               wr_accept;
    logic               wr_drop;

    // A write lands when the slot is empty or is being emptied on this same edge.
    assign wr_accept = i_wr && (!full_q || i_drain);
    assign wr_drop   = i_wr && full_q && !i_drain;

    always_comb begin
        full_d  = full_q;
        frame_d = frame_q;
        if (wr_accept) begin
            full_d  = 1'b1;
            frame_d = i_wr_frame;
        end else if (i_drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            full_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            full_q  <= full_d;
            frame_q <= frame_d;
        end
    end

    assign o_full  = full_q;
    assign o_frame = frame_q;

`ifdef UART_PKT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (wr_drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = wr_drop;
    assign o_drop_cnt  = '0;
`endif

endmodule

// File: rtl/uart_tx_packer.sv
// Frames ADS, MPR and register-response words and arbitrates them (REG > ADS > MPR)
// onto the uart_controller transmit port. Drop counters need UART_PKT_DROP_CNT_EN.
module uart_tx_packer
    import uart_pkg::*;
#(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_RUN,
    input  logic [47:0]           i_ADS_DATA,
    input  logic                  i_ADS_DATA_VALID,
    input  logic [23:0]           i_MPR_DATA,
    input  logic                  i_MPR_DATA_VALID,
    input  logic [15:0]           i_REG_RESP,
    input  logic                  i_REG_RESP_SRC,
    input  logic                  i_REG_RESP_VALID,
    output logic [FRAME_W-1:0]    o_UART_DATA_TX,
    output logic                  o_UART_DATA_TX_VALID,
    input  logic                  i_UART_DATA_TX_READY,
    output logic [DROP_CNT_W-1:0] o_ADS_DROP_CNT,
    output logic [DROP_CNT_W-1:0] o_MPR_DROP_CNT,
    output logic [DROP_CNT_W-1:0] o_REG_DROP_CNT,
    output out_state_e            o_DBG_STATE
);

    // Handshake: a frame transfers on any edge where VALID and READY are both high;
    // VALID and the frame stay constant until then, and VALID is low for at least
    // one cycle between frames.

    logic               reg_full, ads_full, mpr_full;
    logic [FRAME_W-1:0] reg_frame, ads_frame, mpr_frame;
    logic               reg_drain, ads_drain, mpr_drain;

    out_state_e         state_q, state_d;
    logic [FRAME_W-1:0] data_q, data_d;

    uart_pkt_slot #(.DROP_CNT_W(DROP_CNT_W)) u_reg_slot (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_wr       (i_REG_RESP_VALID),
        .i_wr_frame (fmt_reg(i_REG_RESP, i_REG_RESP_SRC)),
        .i_drain    (reg_drain),
        .o_full     (reg_full),
        .o_frame    (reg_frame),
        .o_drop_cnt (o_REG_DROP_CNT)
    );

    uart_pkt_slot #(.DROP_CNT_W(DROP_CNT_W)) u_ads_slot (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_wr       (i_ADS_DATA_VALID && i_RUN),
        .i_wr_frame (fmt_ads(i_ADS_DATA)),
        .i_drain    (ads_drain),
        .o_full     (ads_full),
        .o_frame    (ads_frame),
        .o_drop_cnt (o_ADS_DROP_CNT)
    );

    uart_pkt_slot #(.DROP_CNT_W(DROP_CNT_W)) u_mpr_slot (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_wr       (i_MPR_DATA_VALID && i_RUN),
        .i_wr_frame (fmt_mpr(i_MPR_DATA)),
        .i_drain    (mpr_drain),
        .o_full     (mpr_full),
        .o_frame    (mpr_frame),
        .o_drop_cnt (o_MPR_DROP_CNT)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        reg_drain = 1'b0;
        ads_drain = 1'b0;
        mpr_drain = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (reg_full) begin
                    reg_drain = 1'b1;
                    data_d    = reg_frame;
                    state_d   = OUT_FULL;
                end else if (ads_full) begin
                    ads_drain = 1'b1;
                    data_d    = ads_frame;
                    state_d   = OUT_FULL;
                end else if (mpr_full) begin
                    mpr_drain = 1'b1;
                    data_d    = mpr_frame;
                    state_d   = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (i_UART_DATA_TX_READY) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign o_UART_DATA_TX       = data_q;
    assign o_UART_DATA_TX_VALID = (state_q == OUT_FULL);
    assign o_DBG_STATE          = state_q;

endmodule

// File: doc/uart_tx_packer.md
# uart_tx_packer

Upstream framing and arbitration stage for `uart_controller`. It collects ADS sample words, MPR sample words and register-read responses from the sensor controllers, formats each into the 56-bit UART transmit frame, and presents one frame at a time on the controller's valid/ready transmit port. Each source has a one-entry buffer, so single-cycle data-ready pulses are never lost while a frame is in flight.

## Interface
- `DROP_CNT_W`, default 8: width of the per-source saturating drop counters.
- `i_CLK` in 1: system clock.
- `i_RST` in 1: reset, synchronous, active-high.
- `i_RUN` in 1: streaming enable. When low, ADS and MPR sample pulses are ignored; register responses still pass.
- `i_ADS_DATA` in 48 and `i_ADS_DATA_VALID` in 1: two 24-bit ADS channels, qualified by a 1-cycle pulse.
- `i_MPR_DATA` in 24 and `i_MPR_DATA_VALID` in 1: MPR pressure word, qualified by a 1-cycle pulse.
- `i_REG_RESP` in 16, `i_REG_RESP_SRC` in 1 (0 = ADS, 1 = MPR) and `i_REG_RESP_VALID` in 1: register read response {addr[15:8], data[7:0]}, qualified by a 1-cycle pulse.
- `o_UART_DATA_TX` out 56: frame to `uart_controller`.
- `o_UART_DATA_TX_VALID` out 1: frame valid; held until accepted.
- `i_UART_DATA_TX_READY` in 1: controller ready (level).
- `o_ADS_DROP_CNT`, `o_MPR_DROP_CNT` and `o_REG_DROP_CNT` out DROP_CNT_W: drop counters (see Configuration).

## Operation
- Frame formats:
  - ADS frame is {8'hAA, ads[47:0]}.
  - MPR frame is {24'h0, 8'hBB, mpr[23:0]}.
  - Register response frame is {24'h0, 8'h61 for ADS or 8'h6D for MPR, addr, data, 8'h00}.
- There are three slots (REG, ADS, MPR). Each slot holds a formatted 56-bit frame and a full flag.
- A slot is written on an input pulse when it is empty, or when it is being drained on the same edge.
  - If the slot is full and not draining, the new word is dropped and that source's drop counter increments. The counter saturates at all-ones.
- Output register states:
  - OUT_EMPTY: if any slot is full, load the winning slot into `o_UART_DATA_TX`, set VALID, clear that slot, and go to OUT_FULL.
  - OUT_FULL: on an edge where VALID and READY are both high, the frame is accepted. Clear VALID and go to OUT_EMPTY. A frame may load again no earlier than the next edge.
- Arbitration is fixed priority, REG > ADS > MPR. Register responses are latency-critical; ADS is higher-rate than MPR.
- `i_RUN` falling does not flush full slots or the output register; queued frames still drain.
- While VALID is high, `o_UART_DATA_TX` is stable and VALID never drops without acceptance.

## Timing
- Reset: `o_UART_DATA_TX` = 0, `o_UART_DATA_TX_VALID` = 0, all drop counters = 0, all slots empty, state OUT_EMPTY.
- Latency: an input pulse at edge N fills the slot at N. If the output is empty, VALID is high after edge N+1, so the frame is visible 2 cycles after the pulse.
- Acceptance: an edge where VALID and READY are both high consumes the frame. VALID is low for at least one cycle between frames.
- Simultaneous pulses on all three sources fill all three slots, which then emit in order REG, ADS, MPR.
- Reset asserted mid-frame discards everything. Nothing is emitted until a new pulse arrives.
- A drop counter at all-ones stays at all-ones.

## Configuration
- `UART_PKT_DROP_CNT_EN`:
  - Defined: the three drop counters are implemented as specified.
  - Undefined: the counters are not built and the three drop outputs are tied to 0. Drop behaviour is unchanged.

## Structure
- Package `uart_pkg` holds the header constants (8'hAA, 8'hBB, 8'h61, 8'h6D, 8'h52, 8'h53), the frame width 56, and the output state encoding.
- Sub-module `uart_pkt_slot` is one frame slot: data register, full flag, write/drain handshake, and the optional drop counter. It is instantiated three times.

## Test plan
- ADS pulse with 48'h123456_ABCDEF, READY held high -> after 2 cycles the frame is 56'hAA123456ABCDEF with VALID held for one cycle.
- MPR pulse with 24'h00C0DE, READY low for 10 cycles -> frame 56'h000000BB00C0DE with VALID held stable all 10 cycles, accepted on the first cycle READY is high.
- Register response, src=1, addr 8'h05, data 8'h3C -> frame 56'h0000006D053C00.
- ADS, MPR and REG pulses in the same cycle -> three frames in order 'm'/'a', 0xAA, 0xBB, each separated by at least one VALID-low cycle.
- With READY low and ADS slot plus output full, 300 ADS pulses -> `o_ADS_DROP_CNT` = 255 when the macro is defined, 0 when it is undefined; the first queued frames still emit correctly afterwards.
- `i_RUN` low with an ADS pulse -> no frame. Reset asserted while VALID is high -> VALID = 0 on the next cycle, and no stale frame appears after reset.
